// File: rtl/instr_encoder.sv
// MIPS instruction encoder / program loader: packs symbolic commands into 32-bit words
// and streams them, with incrementing word addresses, into instruction memory via a 2-entry FIFO.
module instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [4:0]        cmd_rs,
    input  logic [4:0]        cmd_rt,
    input  logic [4:0]        cmd_rd,
    input  logic [15:0]       cmd_imm,
    input  logic [25:0]       cmd_target,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err_illegal
);

    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    logic [31:0]       r_buf [2];
    logic              r_rdPtr;
    logic              r_wrPtr;
    logic [1:0]        r_occ;
    logic [ADDR_W:0]   r_issued;
    logic [ADDR_W:0]   r_count;
    logic              r_err;

    logic [31:0]       w_word;
    logic              w_legal;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [1:0]        w_occNext;
    logic [ADDR_W:0]   w_issuedNext;

    always_comb begin
        w_word = '0;
        case (cmd_op)
            4'd0:    w_word = {6'b100011, cmd_rs, cmd_rt, cmd_imm};
            4'd1:    w_word = {6'b101011, cmd_rs, cmd_rt, cmd_imm};
            4'd2:    w_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'b100000};
            4'd3:    w_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'b100010};
            4'd4:    w_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'b101010};
            4'd5:    w_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'b011100};
            4'd6:    w_word = {6'b001000, cmd_rs, cmd_rt, cmd_imm};
            4'd7:    w_word = {6'b000100, cmd_rs, cmd_rt, cmd_imm};
            4'd8:    w_word = {6'b000010, cmd_target};
            default: w_word = '0;
        endcase
    end

    // Ready depends only on registered state, so a full FIFO blocks even while it pops.
    assign w_legal   = (cmd_op <= 4'd8);
    assign cmd_ready = (r_state == S_LOAD) && (r_occ != 2'd2) && (r_issued != CAP);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_push    = w_accept && w_legal;
    assign w_pop     = wr_valid && wr_ready;

    assign wr_valid    = (r_occ != 2'd0);
    assign wr_data     = wr_valid ? r_buf[r_rdPtr] : 32'd0;
    assign wr_addr     = r_count[ADDR_W-1:0];
    assign count       = r_count;
    assign busy        = (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign done        = (r_state == S_DONE);
    assign err_illegal = r_err;

    always_comb begin
        w_occNext = r_occ;
        if (w_push && !w_pop) begin
            w_occNext = r_occ + 2'd1;
        end else if (!w_push && w_pop) begin
            w_occNext = r_occ - 2'd1;
        end
    end

    assign w_issuedNext = r_issued + {{ADDR_W{1'b0}}, w_push};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_rdPtr  <= 1'b0;
            r_wrPtr  <= 1'b0;
            r_occ    <= 2'd0;
            r_issued <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_buf[r_wrPtr] <= w_word;
                r_wrPtr        <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
                r_count <= r_count + {{ADDR_W{1'b0}}, 1'b1};
            end
            r_occ    <= w_occNext;
            r_issued <= w_issuedNext;
            if (w_accept && !w_legal) begin
                r_err <= 1'b1;
            end

            // The FIFO is always empty in IDLE/DONE, so clearing counters here loses nothing.
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state  <= S_LOAD;
                        r_count  <= '0;
                        r_issued <= '0;
                        r_err    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (finish || (w_issuedNext == CAP)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_occNext == 2'd0) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: randomized and directed commands, scoreboard queue
// filled by the stimulus side and drained by an independent write-port monitor.
module tb_instr_encoder;

    localparam int AW  = 2;
    localparam int CAP = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          finish;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [4:0]    cmd_rs;
    logic [4:0]    cmd_rt;
    logic [4:0]    cmd_rd;
    logic [15:0]   cmd_imm;
    logic [25:0]   cmd_target;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic          err_illegal;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
        .cmd_imm(cmd_imm), .cmd_target(cmd_target),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .count(count), .busy(busy), .done(done), .err_illegal(err_illegal)
    );

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } exp_t;

    exp_t        expQ[$];
    int unsigned seenAddr[$];
    logic [31:0] seenData[$];

    int nVec = 0;
    int nErr = 0;

    int unsigned issuedExp = 0;
    bit          errExp    = 0;
    bit          loadExp   = 0;
    int          readyMode = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MIPS field packing from opcode/funct tables, built by plain arithmetic
    function automatic logic [31:0] refWord(input int unsigned op, input int unsigned rs,
                                            input int unsigned rt, input int unsigned rd,
                                            input int unsigned imm, input int unsigned tgt);
        int unsigned opc [9] = '{35, 43, 0, 0, 0, 0, 8, 4, 2};
        int unsigned fn  [9] = '{0, 0, 32, 34, 42, 28, 0, 0, 0};
        int unsigned w;
        if (op == 8)
            w = opc[op] * 32'd67108864 + tgt;
        else if (op >= 2 && op <= 5)
            w = rs * 32'd2097152 + rt * 32'd65536 + rd * 32'd2048 + fn[op];
        else
            w = opc[op] * 32'd67108864 + rs * 32'd2097152 + rt * 32'd65536 + imm;
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        nVec++;
        if (act !== expv) begin
            nErr++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Offers one command; the model is updated on the cycle the handshake is seen.
    task automatic applyStimulus(input int op, input int rs, input int rt, input int rd,
                                 input int imm, input int tgt, input int budget,
                                 input bit checkAcc, output bit accepted);
        bit expAcc;
        expAcc     = loadExp && (issuedExp < CAP);
        accepted   = 1'b0;
        cmd_op     = 4'(op);
        cmd_rs     = 5'(rs);
        cmd_rt     = 5'(rt);
        cmd_rd     = 5'(rd);
        cmd_imm    = 16'(imm);
        cmd_target = 26'(tgt);
        cmd_valid  = 1'b1;
        for (int i = 0; i < budget && !accepted; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                accepted = 1'b1;
                if (op <= 8) begin
                    expQ.push_back('{issuedExp, refWord(op, rs, rt, rd, imm, tgt)});
                    issuedExp++;
                    if (issuedExp == CAP) loadExp = 1'b0;
                end else begin
                    errExp = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (checkAcc) checkOutput("cmdAccept", 32'(accepted), 32'(expAcc));
    endtask

    task automatic doStart();
        issuedExp = 0;
        errExp    = 1'b0;
        loadExp   = 1'b1;
        seenAddr.delete();
        seenData.delete();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic doFinish();
        finish = 1'b1;
        @(posedge clk);
        #1;
        finish  = 1'b0;
        loadExp = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        checkOutput("doneReached", 32'(done), 32'd1);
        checkOutput("finalCount", 32'(count), issuedExp);
        checkOutput("errSticky", 32'(err_illegal), 32'(errExp));
        checkOutput("busyLow", 32'(busy), 32'd0);
        checkOutput("writesSeen", seenData.size(), issuedExp);
        checkOutput("queueDrained", expQ.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        wr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       wr_ready = 1'b0;
                1:       wr_ready = 1'b1;
                default: wr_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Write-port monitor: pops the scoreboard on each handshake and checks stall stability.
    initial begin
        bit          havePrev;
        bit          prevValid;
        bit          prevReady;
        logic [AW-1:0] prevAddr;
        logic [31:0] prevData;
        exp_t        e;
        havePrev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                havePrev = 1'b0;
            end else begin
                if (havePrev && prevValid && !prevReady) begin
                    checkOutput("stallValid", 32'(wr_valid), 32'd1);
                    checkOutput("stallAddr", 32'(wr_addr), 32'(prevAddr));
                    checkOutput("stallData", wr_data, prevData);
                end
                if (wr_valid && wr_ready) begin
                    if (expQ.size() == 0) begin
                        checkOutput("spuriousWrite", 32'(wr_valid), 32'd0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("wrAddr", 32'(wr_addr), e.addr);
                        checkOutput("wrData", wr_data, e.data);
                    end
                    seenAddr.push_back(32'(wr_addr));
                    seenData.push_back(wr_data);
                end
                havePrev  = 1'b1;
                prevValid = wr_valid;
                prevReady = wr_ready;
                prevAddr  = wr_addr;
                prevData  = wr_data;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;
        int op;
        int n;
        rst_n      = 1'b1;
        start      = 1'b0;
        finish     = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = '0;
        cmd_rs     = '0;
        cmd_rt     = '0;
        cmd_rd     = '0;
        cmd_imm    = '0;
        cmd_target = '0;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rstCmdReady", 32'(cmd_ready), 32'd0);
        checkOutput("rstWrValid", 32'(wr_valid), 32'd0);
        checkOutput("rstWrAddr", 32'(wr_addr), 32'd0);
        checkOutput("rstWrData", wr_data, 32'd0);
        checkOutput("rstCount", 32'(count), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstErr", 32'(err_illegal), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] first ADD latency");
        readyMode = 1;
        doStart();
        checkOutput("startBusy", 32'(busy), 32'd1);
        checkOutput("startReady", 32'(cmd_ready), 32'd1);
        applyStimulus(2, 1, 2, 3, 0, 0, 5, 1, acc);
        checkOutput("addValid", 32'(wr_valid), 32'd1);
        checkOutput("addAddr", 32'(wr_addr), 32'd0);
        checkOutput("addData", wr_data, 32'h00221820);
        @(posedge clk);
        #1;
        checkOutput("addCount", 32'(count), 32'd1);
        doFinish();
        waitDone(20);

        $display("[TB] LW / BEQ / J words");
        doStart();
        applyStimulus(0, 29, 8, 0, 16'h0004, 0, 5, 1, acc);
        applyStimulus(7, 4, 5, 0, 16'hFFFF, 0, 5, 1, acc);
        applyStimulus(8, 0, 0, 0, 0, 26'h0000010, 5, 1, acc);
        doFinish();
        waitDone(20);
        if (seenData.size() == 3) begin
            checkOutput("lwWord", seenData[0], 32'h8FA80004);
            checkOutput("beqWord", seenData[1], 32'h1085FFFF);
            checkOutput("jWord", seenData[2], 32'h08000010);
            checkOutput("jAddr", seenAddr[2], 32'd2);
        end

        $display("[TB] backpressure");
        readyMode = 0;
        doStart();
        applyStimulus(2, 1, 1, 1, 0, 0, 5, 1, acc);
        applyStimulus(3, 2, 2, 2, 0, 0, 5, 1, acc);
        applyStimulus(4, 3, 3, 3, 0, 0, 5, 0, acc);
        checkOutput("fullNoAccept", 32'(acc), 32'd0);
        checkOutput("fullReadyLow", 32'(cmd_ready), 32'd0);
        checkOutput("fullHeadData", wr_data, refWord(2, 1, 1, 1, 0, 0));
        readyMode = 1;
        applyStimulus(4, 3, 3, 3, 0, 0, 10, 1, acc);
        doFinish();
        waitDone(20);
        for (int i = 0; i < seenAddr.size(); i++) checkOutput("bpOrder", seenAddr[i], i);

        $display("[TB] illegal op");
        doStart();
        applyStimulus(2, 5, 6, 7, 0, 0, 5, 1, acc);
        applyStimulus(12, 5, 6, 7, 0, 0, 5, 1, acc);
        @(negedge clk);
        checkOutput("illegalSet", 32'(err_illegal), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(2, 8, 9, 10, 0, 0, 5, 1, acc);
        doFinish();
        waitDone(20);
        doStart();
        checkOutput("illegalCleared", 32'(err_illegal), 32'd0);
        doFinish();
        waitDone(20);

        $display("[TB] capacity saturation");
        doStart();
        for (int i = 0; i < 5; i++) applyStimulus(6, i, i + 1, 0, i * 3, 0, (i < 4) ? 10 : 4, 1, acc);
        checkOutput("fifthRejected", 32'(acc), 32'd0);
        waitDone(20);
        doStart();
        applyStimulus(5, 1, 2, 3, 0, 0, 5, 1, acc);
        applyStimulus(1, 4, 5, 0, 16'h1234, 0, 5, 1, acc);
        doFinish();
        waitDone(20);

        $display("[TB] reset during drain");
        readyMode = 0;
        doStart();
        applyStimulus(2, 1, 2, 3, 0, 0, 5, 1, acc);
        applyStimulus(3, 4, 5, 6, 0, 0, 5, 1, acc);
        doFinish();
        checkOutput("drainBusy", 32'(busy), 32'd1);
        checkOutput("drainValid", 32'(wr_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstValid", 32'(wr_valid), 32'd0);
        checkOutput("midRstAddr", 32'(wr_addr), 32'd0);
        checkOutput("midRstData", wr_data, 32'd0);
        checkOutput("midRstCount", 32'(count), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstReady", 32'(cmd_ready), 32'd0);
        expQ.delete();
        issuedExp = 0;
        loadExp   = 1'b0;
        readyMode = 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("postRstNoWrite", 32'(wr_valid), 32'd0);
            checkOutput("postRstIdle", 32'(busy | done), 32'd0);
        end
        @(posedge clk);
        #1;

        $display("[TB] randomized loads");
        for (int l = 0; l < 25; l++) begin
            readyMode = 2;
            doStart();
            n = $urandom_range(0, 6);
            for (int c = 0; c < n; c++) begin
                if (loadExp && $urandom_range(0, 7) == 0) doFinish();
                op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
                applyStimulus(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                              $urandom_range(0, 65535), int'($urandom & 32'h03FF_FFFF),
                              (loadExp && issuedExp < CAP) ? 60 : 3, 1, acc);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            if (loadExp) doFinish();
            waitDone(200);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder and program loader. Accepts symbolic instruction commands (operation select plus register, immediate and target fields) over a valid/ready handshake. Packs each command into a 32-bit instruction word using the same opcode/funct encodings the control unit decodes. Streams the words, with incrementing word addresses, into the instruction-memory write port through a 2-entry buffer. It sits between the test/boot host and instruction memory, ahead of the datapath and control unit.

## Interface
Parameters:
- ADDR_W, 6, instruction-memory word-address width; capacity is 2^ADDR_W words.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse; in IDLE or DONE: clear counters and err_illegal, enter LOAD
- finish  in  1  pulse; in LOAD: stop accepting, enter DRAIN
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted on cycles where cmd_valid && cmd_ready
- cmd_op  in  4  0 LW, 1 SW, 2 ADD, 3 SUB, 4 SLT, 5 MUL, 6 ADDI, 7 BEQ, 8 J, 9-15 illegal
- cmd_rs, cmd_rt, cmd_rd  in  5 each  register fields
- cmd_imm  in  16  immediate (LW/SW/ADDI/BEQ)
- cmd_target  in  26  jump target (J)
- wr_valid  out  1  instruction word pending
- wr_ready  in  1  memory accepts word when wr_valid && wr_ready
- wr_addr  out  ADDR_W  word address of pending word
- wr_data  out  32  encoded instruction
- count  out  ADDR_W+1  words written since start
- busy  out  1  state is LOAD or DRAIN
- done  out  1  state is DONE
- err_illegal  out  1  sticky; an illegal cmd_op was accepted

## Operation
- Encoding:
  - R-type (ADD/SUB/SLT/MUL): op=000000, rs[25:21], rt[20:16], rd[15:11], shamt=0, funct ADD 100000, SUB 100010, SLT 101010, MUL 011100.
  - I-type: op LW 100011, SW 101011, ADDI 001000, BEQ 000100; rs[25:21], rt[20:16], imm[15:0]; rd ignored.
  - J: op 000010, target[25:0]; other fields ignored.
- FSM: IDLE -> LOAD on start. LOAD -> DRAIN on finish. LOAD -> DRAIN automatically when issued count reaches 2^ADDR_W. DRAIN -> DONE when buffer is empty. DONE -> LOAD on start. start is ignored in LOAD/DRAIN; finish is ignored outside LOAD.
- cmd_ready = (state==LOAD) && buffer occupancy < 2 && issued < 2^ADDR_W. No combinational bypass: a full buffer holds cmd_ready low even if it pops in the same cycle.
- Legal accepted command: encode, push into buffer, issued += 1.
- Illegal accepted command: handshake completes, nothing is pushed, issued is unchanged, err_illegal is set.
- Buffer is a 2-entry FIFO, in order. The head drives wr_data. wr_addr = count[ADDR_W-1:0]. Each write handshake increments count.
- Simultaneous push and pop leave occupancy unchanged.
- Counters are ADDR_W+1 bits wide and saturate at 2^ADDR_W by construction; wr_addr never wraps within one load.

## Timing
- Reset (async assert, synchronous release effect): state IDLE, buffer empty. cmd_ready=0, wr_valid=0, wr_addr=0, wr_data=0, count=0, busy=0, done=0, err_illegal=0.
- Reset mid-operation discards buffered words; no partial write is issued afterwards.
- Latency: command accepted at edge N -> wr_valid=1 with its word from edge N (visible cycle N+1).
- Throughput: 1 word/cycle with wr_ready held high.
- wr_valid && !wr_ready: wr_data and wr_addr hold stable; wr_valid does not drop until the handshake.
- start at edge N: busy=1 and cmd_ready=1 from cycle N+1.
- done asserts the cycle after the last write handshake in DRAIN.

## Test plan
- start; ADD rs=1 rt=2 rd=3 with wr_ready=1 -> next cycle wr_valid=1, wr_addr=0, wr_data=0x00221820; count=1.
- LW rs=29 rt=8 imm=0x0004, BEQ rs=4 rt=5 imm=0xFFFF, J target=0x0000010 -> words 0x8FA80004, 0x1085FFFF, 0x08000010 at addresses 0, 1, 2.
- wr_ready=0; offer 3 commands -> 2 accepted, cmd_ready=0, wr_data stable at the first word. Release wr_ready -> addresses 0, 1, 2 in order, no loss or duplication.
- Illegal cmd_op=12 between two ADDs -> err_illegal=1, the ADDs land at addresses 0 and 1, count=2. A subsequent start clears err_illegal.
- ADDR_W=2; offer 5 commands -> 4 written at addresses 0..3, 5th never accepted, done=1, count=4. Likewise, finish after 2 commands -> done after both writes, count=2.
- Assert rst_n low in DRAIN with 2 buffered words -> all outputs at reset values immediately; no writes after release.
